bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//   Master-side bus interface: the initiator end of the arbiter's request/grant protocol. Accepts one local
//   read/write command, raises request + slave select to the Arbiter, waits for grant, then moves address and
//   data bit-serially to the selected slave. Ends with a one-cycle trans_done to the Arbiter and a response to
//   the local master. One instance per master (m1, m2).
// PARAMETERS
//   ADDR_WIDTH    12   address bits shifted per transaction
//   DATA_WIDTH    8    data bits per read or write
//   SEL_WIDTH     2    slave select width; must match the Arbiter's slave_sel
//   TIMEOUT       255  max consecutive stall cycles before abort; 0 disables the timeout
// PORTS
//   clk          in   1           clock; all logic on the rising edge
//   rst          in   1           synchronous reset, active-high
//   cmd_valid    in   1           local command present
//   cmd_ready    out  1           high only in IDLE; command accepted when cmd_valid && cmd_ready
//   cmd_write    in   1           1 = write, 0 = read
//   cmd_slave    in   SEL_WIDTH   target slave
//   cmd_addr     in   ADDR_WIDTH  target address
//   cmd_wdata    in   DATA_WIDTH  write data
//   rsp_valid    out  1           one-cycle pulse: transaction finished
//   rsp_rdata    out  DATA_WIDTH  read data; valid with rsp_valid on a successful read, held until next rsp
//   rsp_error    out  1           valid with rsp_valid: 1 = timeout or grant lost
//   m_request    out  1           request to Arbiter
//   m_slave_sel  out  SEL_WIDTH   registered cmd_slave, stable from REQ to DONE
//   m_grant      in   1           grant from Arbiter
//   trans_done   out  1           one-cycle pulse to Arbiter in DONE
//   bus_valid    out  1           serial bit on bus_dout is valid
//   bus_mode     out  1           registered cmd_write, driven while bus_valid
//   bus_dout     out  1           serial address/write data, LSB first
//   bus_ready    in   1           slave accepts bus_dout this cycle
//   bus_rvalid   in   1           slave drives a read bit on bus_din
//   bus_din      in   1           serial read data, LSB first
// BEHAVIOUR
//   Reset: state=IDLE; cmd_ready=1; every other output 0 (rsp_rdata=0). Reset in any state aborts with no
//     rsp_valid and no trans_done.
//   States: IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE.
//   IDLE: on accept, latch write/slave/addr/wdata -> REQ.
//   REQ: m_request=1. If m_grant=1 -> ADDR. No timeout in REQ; the Arbiter guarantees service.
//   ADDR: bus_valid=1, bus_dout=addr bit[idx]. idx advances only on cycles with bus_ready=1.
//     After bit ADDR_WIDTH-1 is accepted -> WDATA (write) or RWAIT (read).
//   WDATA: same handshake over DATA_WIDTH bits of wdata; last bit accepted -> DONE.
//   RWAIT/RDATA: bus_valid=0. Each cycle with bus_rvalid=1 shifts bus_din in, LSB first; the first bit moves
//     RWAIT->RDATA. After DATA_WIDTH bits -> DONE.
//   m_request=1 in REQ..RDATA, 0 in IDLE and DONE.
//   DONE (1 cycle): trans_done=1; rsp_valid=1; -> IDLE. cmd_ready returns the next cycle; back-to-back
//     commands therefore have a minimum of 1 idle cycle.
//   Stall counter: counts consecutive cycles in ADDR/WDATA with bus_ready=0, or in RWAIT/RDATA with
//     bus_rvalid=0. Clears on any progress or state change. When it reaches TIMEOUT -> DONE with rsp_error=1.
//   Grant lost: m_grant=0 in ADDR..RDATA -> DONE with rsp_error=1, same cycle as detection+1.
//     A timeout and a grant loss in the same cycle give one DONE, error=1.
//   Error responses drive rsp_rdata=0.
//   Bit index width is clog2(max(ADDR_WIDTH,DATA_WIDTH)); it resets to 0 on every state entry.
//   Latency, no stalls, grant present in REQ: accept at cycle 0 -> DONE at cycle 2+ADDR_WIDTH+DATA_WIDTH
//     for a write (22 at defaults); a read adds slave turnaround.
// STRUCTURE
//   bus_pkg: state enum/localparams, MODE_READ/MODE_WRITE, SEL_WIDTH default; shared with Arbiter and slave
//     port.
//   Sub-module serial_shifter: parallel-load PISO/SIPO with bit counter and last-bit flag, instantiated once.
//     Used for addr, wdata and rdata via a load mux.
//   FSM, stall counter and response registers live in bus_master_port.
// TESTING
//   Write, slave 2, addr 0xA5C, data 0x3C, grant at REQ, bus_ready=1 -> bus_dout LSB-first 0xA5C then 0x3C,
//     trans_done and rsp_valid at cycle 22, error=0.
//   Read, slave 1, slave returns 0x96 after 3-cycle turnaround -> rsp_rdata=0x96, error=0, single trans_done.
//   Write with bus_ready low on every other cycle -> each bit is held until accepted, no bit skipped or
//     duplicated.
//   Grant delayed 10 cycles -> m_request and m_slave_sel are held stable throughout, with no bus_valid before
//     grant.
//   Read with bus_rvalid never asserted, TIMEOUT=255 -> DONE after 255 stall cycles, rsp_error=1, rdata=0,
//     trans_done pulses.
//   m_grant dropped mid-ADDR -> DONE with error=1. Reset pulsed mid-WDATA -> IDLE, all outputs 0, no
//     trans_done.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the arbiter/master/slave bus
// Contents: master port state encoding, bus_mode values, default slave select width,
// and a small integer max helper used for parameter sizing.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } bus_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int SEL_WIDTH_DEF = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - parallel-load PISO/SIPO with bit index and last-bit flag
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         load load_data, set final index to load_last, restart index at 0
//   load_data    parallel word (PISO source, or cleared word before SIPO capture)
//   load_last    index of the final bit of this word
//   shift        advance the bit index (one bit accepted or received)
//   capture      with shift: write sin into the current bit position
//   sin          serial input bit
//   sout         bit at the current index (LSB first)
//   rdata        low RD_W bits of the word (received data)
//   last         current index is the final bit
module serial_shifter #(
  parameter int WIDTH = 12,
  parameter int IDX_W = 4,
  parameter int RD_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDX_W-1:0] load_last,
  input  logic             shift,
  input  logic             capture,
  input  logic             sin,
  output logic             sout,
  output logic [RD_W-1:0]  rdata,
  output logic             last
);

  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;

  // Bits are addressed in place rather than physically shifted so the same
  // register serves both as transmit source and receive destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      data_q <= load_data;
      idx_q  <= '0;
      last_q <= load_last;
    end else if (shift) begin
      if (capture) begin
        data_q[idx_q] <= sin;
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  assign sout  = data_q[idx_q];
  assign rdata = data_q[RD_W-1:0];
  assign last  = (idx_q == last_q);

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - initiator end of the arbiter request/grant bus
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              local command handshake (ready only in IDLE)
//   cmd_write/slave/addr/wdata       command fields, latched on accept
//   rsp_valid/rsp_rdata/rsp_error    one-cycle response; rdata held between responses
//   m_request/m_slave_sel/m_grant    arbiter request, registered slave select, grant
//   trans_done                       one-cycle end-of-transaction pulse to the arbiter
//   bus_valid/bus_mode/bus_dout      serial address/write data out, LSB first
//   bus_ready                        slave accepts bus_dout this cycle
//   bus_rvalid/bus_din               serial read data in, LSB first
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [SEL_WIDTH-1:0]  cmd_slave,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  m_request,
  output logic [SEL_WIDTH-1:0]  m_slave_sel,
  input  logic                  m_grant,
  output logic                  trans_done,
  output logic                  bus_valid,
  output logic                  bus_mode,
  output logic                  bus_dout,
  input  logic                  bus_ready,
  input  logic                  bus_rvalid,
  input  logic                  bus_din
);

  localparam int MAXW    = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int IDX_W   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_t state_q, state_d;

  logic                  write_q;
  logic [SEL_WIDTH-1:0]  slave_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [STALL_W-1:0]    stall_q, stall_d;

  logic accept, in_tx, in_rd, stall, timeout_hit, err_set;

  logic                  sh_load, sh_shift, sh_capture, sh_sout, sh_last;
  logic [MAXW-1:0]       sh_load_data;
  logic [IDX_W-1:0]      sh_load_last;
  logic [DATA_WIDTH-1:0] sh_rdata;
  logic [DATA_WIDTH-1:0] rsp_now;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign in_tx  = (state_q == ST_ADDR)  || (state_q == ST_WDATA);
  assign in_rd  = (state_q == ST_RWAIT) || (state_q == ST_RDATA);

  // A stall is a bus cycle where the slave made no progress in the current direction.
  assign stall       = (in_tx && !bus_ready) || (in_rd && !bus_rvalid);
  assign timeout_hit = (TIMEOUT != 0) && stall && (stall_q == STALL_W'(TIMEOUT - 1));

  assign sh_shift   = (in_tx && bus_ready) || (in_rd && bus_rvalid);
  assign sh_capture = in_rd;

  serial_shifter #(
    .WIDTH (MAXW),
    .IDX_W (IDX_W),
    .RD_W  (DATA_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_load_data),
    .load_last (sh_load_last),
    .shift     (sh_shift),
    .capture   (sh_capture),
    .sin       (bus_din),
    .sout      (sh_sout),
    .rdata     (sh_rdata),
    .last      (sh_last)
  );

  always_comb begin
    state_d      = state_q;
    err_set      = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_load_last = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (m_grant) begin
          state_d      = ST_ADDR;
          sh_load      = 1'b1;
          sh_load_data = MAXW'(addr_q);
          sh_load_last = IDX_W'(ADDR_WIDTH - 1);
        end
      end
      ST_ADDR, ST_WDATA, ST_RWAIT, ST_RDATA: begin
        // Grant loss and timeout share one abort path, so both together still
        // produce a single DONE.
        if (!m_grant || timeout_hit) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end else begin
          case (state_q)
            ST_ADDR: begin
              if (bus_ready && sh_last) begin
                sh_load      = 1'b1;
                sh_load_last = IDX_W'(DATA_WIDTH - 1);
                if (write_q == MODE_WRITE) begin
                  state_d      = ST_WDATA;
                  sh_load_data = MAXW'(wdata_q);
                end else begin
                  state_d = ST_RWAIT;
                end
              end
            end
            ST_WDATA: begin
              if (bus_ready && sh_last) state_d = ST_DONE;
            end
            ST_RWAIT: begin
              // The index keeps counting into RDATA: bit 0 is captured here.
              if (bus_rvalid) state_d = sh_last ? ST_DONE : ST_RDATA;
            end
            default: begin
              if (bus_rvalid && sh_last) state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    stall_d = ((state_d != state_q) || !stall) ? '0 : stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= MODE_READ;
      slave_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (accept) begin
        write_q <= cmd_write;
        slave_q <= cmd_slave;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        err_q   <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (state_q == ST_DONE) rdata_q <= rsp_now;
    end
  end

  // Response data is presented combinationally during DONE (the shifter still
  // holds the received word) and then held in rdata_q until the next response.
  assign rsp_now = (err_q || (write_q == MODE_WRITE)) ? '0 : sh_rdata;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign m_request   = (state_q == ST_REQ) || in_tx || in_rd;
  assign m_slave_sel = slave_q;
  assign bus_valid   = in_tx;
  assign bus_mode    = in_tx && write_q;
  assign bus_dout    = in_tx && sh_sout;
  assign trans_done  = (state_q == ST_DONE);
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_error   = (state_q == ST_DONE) && err_q;
  assign rsp_rdata   = (state_q == ST_DONE) ? rsp_now : rdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - scoreboard bench for bus_master_port
module tb_bus_master_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [SW-1:0] cmd_slave = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          m_request;
  logic [SW-1:0] m_slave_sel;
  logic          m_grant;
  logic          trans_done;
  logic          bus_valid;
  logic          bus_mode;
  logic          bus_dout;
  logic          bus_ready;
  logic          bus_rvalid;
  logic          bus_din;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SEL_WIDTH  (SW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_slave   (cmd_slave),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .m_request   (m_request),
    .m_slave_sel (m_slave_sel),
    .m_grant     (m_grant),
    .trans_done  (trans_done),
    .bus_valid   (bus_valid),
    .bus_mode    (bus_mode),
    .bus_dout    (bus_dout),
    .bus_ready   (bus_ready),
    .bus_rvalid  (bus_rvalid),
    .bus_din     (bus_din)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_rdata;
    int            lat;
  } rsp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rsp_t          exp_rsp[$];
  logic          exp_bits[$];
  logic          exp_mode  = 1'b0;
  logic [SW-1:0] exp_slave = '0;

  // Environment behaviour for the current transaction.
  int            grant_delay = 0;
  int            drop_at     = -1;
  int            ready_pat   = 0;
  int            rd_turn     = -1;
  bit            rd_gaps     = 1'b0;
  logic [DW-1:0] rd_data     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbiter + slave model: drives grant, bus_ready and read bits at each negedge.
  initial begin : drv
    int req_cnt, bv_cnt, rd_cyc, rd_bit;
    bit dropped, seen_bv, tog, r;
    req_cnt = 0; bv_cnt = 0; rd_cyc = 0; rd_bit = 0;
    dropped = 0; seen_bv = 0; tog = 0; r = 0;
    m_grant = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_din = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!m_request || rst) begin
        req_cnt = 0; bv_cnt = 0; rd_cyc = 0; rd_bit = 0;
        dropped = 0; seen_bv = 0; tog = 0;
        m_grant = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_din = 1'b0;
      end else begin
        if (bus_valid) begin
          seen_bv = 1;
          if (drop_at >= 0 && bv_cnt >= drop_at) dropped = 1;
          bv_cnt++;
        end
        m_grant = !dropped && (req_cnt >= grant_delay);
        req_cnt++;
        case (ready_pat)
          0:       r = 1;
          1:       begin r = tog; tog = !tog; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        bus_ready  = bus_valid && r;
        bus_rvalid = 1'b0;
        bus_din    = 1'b0;
        if (!bus_valid && seen_bv) begin
          if (rd_turn >= 0 && rd_cyc >= rd_turn && rd_bit < DW &&
              (!rd_gaps || $urandom_range(0, 1) == 1)) begin
            bus_rvalid = 1'b1;
            bus_din    = rd_data[rd_bit];
            rd_bit++;
          end
          rd_cyc++;
        end
      end
    end
  end

  // Monitor: compares every accepted bus bit and every response against the scoreboard.
  initial begin : mon
    int   acc_cyc;
    bit   gseen;
    rsp_t e;
    logic b;
    acc_cyc = 0;
    gseen   = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (m_request) begin
          chk("slave_sel_stable", 32'(m_slave_sel), 32'(exp_slave));
          if (bus_valid) chk("bus_valid_after_grant", 32'(gseen), 32'd1);
          gseen = gseen | m_grant;
        end else begin
          gseen = 0;
        end
        if (bus_valid && bus_ready) begin
          chk("bus_mode", 32'(bus_mode), 32'(exp_mode));
          if (exp_bits.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_bit: got an accepted bit, expected none (cycle %0d)", cyc);
          end else begin
            b = exp_bits.pop_front();
            chk("bus_dout", 32'(bus_dout), 32'(b));
          end
        end
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0 (cycle %0d)", cyc);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
            chk("trans_done_with_rsp", 32'(trans_done), 32'd1);
            if (e.chk_rdata) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            if (e.lat >= 0) chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            if (!e.err) chk("bits_left", 32'(exp_bits.size()), 32'd0);
            exp_bits.delete();
          end
        end else if (trans_done) begin
          chk("trans_done_without_rsp", 32'(rsp_valid), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic err, input int lat,
                       input int gd, input int drop, input int rp, input int turn,
                       input bit gaps, input logic [DW-1:0] rdd);
    rsp_t e;
    grant_delay = gd; drop_at = drop; ready_pat = rp;
    rd_turn = turn; rd_gaps = gaps; rd_data = rdd;
    exp_mode  = w;
    exp_slave = s;
    for (int i = 0; i < AW; i++) exp_bits.push_back(a[i]);
    if (w) for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    e.err       = err;
    e.rdata     = (err || w) ? '0 : rdd;
    e.chk_rdata = err || !w;
    e.lat       = lat;
    exp_rsp.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_slave = s; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && cmd_ready) return;
    end
    tests++;
    fails++;
    $display("FAIL rsp_wait: got no response within %0d cycles, expected one", budget);
    exp_rsp.delete();
    exp_bits.delete();
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name,
        {cmd_ready, rsp_valid, rsp_error, rsp_rdata, m_request, m_slave_sel,
         trans_done, bus_valid, bus_mode, bus_dout},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk_idle_outputs("reset_outputs");

    // Directed write: 0xA5C then 0x3C, done 22 cycles after accept.
    issue(1'b1, 2'd2, 12'hA5C, 8'h3C, 1'b0, 22, 0, -1, 0, -1, 1'b0, 8'h00);
    wait_done(100);

    // Read with 3-cycle turnaround.
    issue(1'b0, 2'd1, 12'h123, 8'h00, 1'b0, 25, 0, -1, 0, 3, 1'b0, 8'h96);
    wait_done(100);

    // Write with bus_ready low every other cycle.
    issue(1'b1, 2'd0, 12'h5E7, 8'hC9, 1'b0, -1, 0, -1, 1, -1, 1'b0, 8'h00);
    wait_done(200);

    // Grant delayed 10 cycles: 10 extra REQ cycles.
    issue(1'b1, 2'd3, 12'h0F1, 8'hA6, 1'b0, 32, 10, -1, 0, -1, 1'b0, 8'h00);
    wait_done(100);

    // Read with no bus_rvalid: timeout after 255 stall cycles in RWAIT.
    issue(1'b0, 2'd2, 12'h7AA, 8'h00, 1'b1, 2 + AW + TO, 0, -1, 0, -1, 1'b0, 8'h55);
    wait_done(400);

    // Grant dropped on the 6th ADDR cycle.
    issue(1'b0, 2'd1, 12'h3C3, 8'h00, 1'b1, 8, 0, 5, 0, 2, 1'b0, 8'hFF);
    wait_done(100);

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), AW'($urandom),
            DW'($urandom), 1'b0, -1, int'($urandom_range(0, 4)), -1, 2,
            int'($urandom_range(0, 4)), 1'b1, DW'($urandom));
      wait_done(300);
    end

    // Reset pulsed mid-WDATA: no response, outputs back to reset values.
    issue(1'b1, 2'd3, 12'hFFF, 8'hFF, 1'b0, -1, 0, -1, 0, -1, 1'b0, 8'h00);
    n = 0;
    while (exp_bits.size() > DW - 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wdata", 32'(n < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rsp.delete();
    exp_bits.delete();
    #3;
    chk_idle_outputs("mid_wdata_reset_outputs");
    repeat (6) @(negedge clk);

    // Recovery after reset.
    issue(1'b1, 2'd1, 12'h246, 8'h81, 1'b0, 22, 0, -1, 0, -1, 1'b0, 8'h00);
    wait_done(100);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
